// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter sharing one SPI memory controller between two request/ready masters,
// one transaction at a time, with a watchdog that aborts transactions the controller never completes.
module spi_mem_arbiter #(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_ready,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [DATA_W-1:0] ABORT_DATA = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_c;

    logic               m_req_d, m_we_d, owner_d, busy_d, timeout_err_d;
    logic [ADDR_W-1:0]  m_addr_d;
    logic [DATA_W-1:0]  m_wdata_d, p0_rdata_d, p1_rdata_d;
    logic               p0_ready_d, p1_ready_d;

    // Winner selection: a lone requester wins; a tie goes by mode.
    always_comb begin
        win_c = 1'b0;
        if (p0_req && p1_req) begin
            win_c = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
        end else begin
            win_c = ~p0_req;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        m_req_d       = m_req;
        m_we_d        = m_we;
        m_addr_d      = m_addr;
        m_wdata_d     = m_wdata;
        owner_d       = owner;
        busy_d        = busy;
        p0_rdata_d    = p0_rdata;
        p1_rdata_d    = p1_rdata;
        p0_ready_d    = 1'b0;
        p1_ready_d    = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    m_we_d       = win_c ? p1_we    : p0_we;
                    m_addr_d     = win_c ? p1_addr  : p0_addr;
                    m_wdata_d    = win_c ? p1_wdata : p0_wdata;
                    owner_d      = win_c;
                    last_grant_d = win_c;
                    m_req_d      = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    if (!m_we) begin
                        if (owner) p1_rdata_d = m_rdata;
                        else       p0_rdata_d = m_rdata;
                    end
                    p0_ready_d = ~owner;
                    p1_ready_d = owner;
                    m_req_d    = 1'b0;
                    state_d    = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    if (owner) p1_rdata_d = ABORT_DATA;
                    else       p0_rdata_d = ABORT_DATA;
                    p0_ready_d    = ~owner;
                    p1_ready_d    = owner;
                    timeout_err_d = 1'b1;
                    m_req_d       = 1'b0;
                    state_d       = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once, even mid-transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            p0_ready     <= 1'b0;
            p1_ready     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_req        <= m_req_d;
            m_we         <= m_we_d;
            m_addr       <= m_addr_d;
            m_wdata      <= m_wdata_d;
            owner        <= owner_d;
            busy         <= busy_d;
            p0_rdata     <= p0_rdata_d;
            p1_rdata     <= p1_rdata_d;
            p0_ready     <= p0_ready_d;
            p1_ready     <= p1_ready_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: a round-robin and a fixed-priority instance, each checked every
// cycle against a transaction-level model, plus directed scenarios with literal expectations.
module tb_spi_mem_arbiter;
    localparam int unsigned NI = 2;
    localparam int          TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req   [NI][2];
    logic        we    [NI][2];
    logic [15:0] addr  [NI][2];
    logic [15:0] wdata [NI][2];
    logic [15:0] rdata [NI][2];
    logic        rdy   [NI][2];
    logic        m_req   [NI];
    logic        m_we    [NI];
    logic [15:0] m_addr  [NI];
    logic [15:0] m_wdata [NI];
    logic [15:0] m_rdata [NI];
    logic        m_ready [NI];
    logic        owner   [NI];
    logic        busy    [NI];
    logic        terr    [NI];

    spi_mem_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .reset(reset),
        .p0_req(req[0][0]), .p0_we(we[0][0]), .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]),
        .p0_rdata(rdata[0][0]), .p0_ready(rdy[0][0]),
        .p1_req(req[0][1]), .p1_we(we[0][1]), .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]),
        .p1_rdata(rdata[0][1]), .p1_ready(rdy[0][1]),
        .m_req(m_req[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .m_ready(m_ready[0]),
        .owner(owner[0]), .busy(busy[0]), .timeout_err(terr[0])
    );

    spi_mem_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(req[1][0]), .p0_we(we[1][0]), .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]),
        .p0_rdata(rdata[1][0]), .p0_ready(rdy[1][0]),
        .p1_req(req[1][1]), .p1_we(we[1][1]), .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]),
        .p1_rdata(rdata[1][1]), .p1_ready(rdy[1][1]),
        .m_req(m_req[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .m_ready(m_ready[1]),
        .owner(owner[1]), .busy(busy[1]), .timeout_err(terr[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 = free, 1 = transaction outstanding, 2 = completion cycle.
    int          ph     [NI];
    int          waited [NI];
    bit          last   [NI];
    bit          e_mreq [NI];
    bit          e_we   [NI];
    bit          e_owner[NI];
    bit          e_busy [NI];
    bit          e_terr [NI];
    logic [15:0] e_addr [NI];
    logic [15:0] e_wdata[NI];
    bit          e_rdy  [NI][2];
    logic [15:0] e_rdata[NI][2];

    task automatic model_reset(int k);
        ph[k] = 0; waited[k] = 0; last[k] = 1'b1;
        e_mreq[k] = 0; e_we[k] = 0; e_owner[k] = 0; e_busy[k] = 0; e_terr[k] = 0;
        e_addr[k] = '0; e_wdata[k] = '0;
        for (int p = 0; p < 2; p++) begin
            e_rdy[k][p] = 0;
            e_rdata[k][p] = '0;
        end
    endtask

    task automatic model_step(int k);
        bit w;
        if (reset) begin
            model_reset(k);
            return;
        end
        e_rdy[k][0] = 0; e_rdy[k][1] = 0; e_terr[k] = 0;
        if (ph[k] == 0) begin
            if (req[k][0] || req[k][1]) begin
                if (req[k][0] && req[k][1]) w = (k == 1) ? 1'b0 : !last[k];
                else                        w = req[k][1];
                last[k] = w; e_owner[k] = w;
                e_we[k] = we[k][w]; e_addr[k] = addr[k][w]; e_wdata[k] = wdata[k][w];
                e_mreq[k] = 1; e_busy[k] = 1; waited[k] = 0; ph[k] = 1;
            end
        end else if (ph[k] == 1) begin
            waited[k]++;
            if (m_ready[k]) begin
                if (!e_we[k]) e_rdata[k][e_owner[k]] = m_rdata[k];
                e_rdy[k][e_owner[k]] = 1; e_mreq[k] = 0; ph[k] = 2;
            end else if (waited[k] >= TO) begin
                e_rdata[k][e_owner[k]] = 16'hFFFF;
                e_rdy[k][e_owner[k]] = 1; e_terr[k] = 1; e_mreq[k] = 0; ph[k] = 2;
            end
        end else begin
            e_busy[k] = 0; ph[k] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) model_reset(k);
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_step(k);
        end
    end

    // Per-cycle comparison against the model; also logs which port each new m_req serves.
    int dgr0[$];
    int dgr1[$];
    bit prev_mreq [NI];
    initial begin
        for (int k = 0; k < NI; k++) prev_mreq[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("m_req", k, m_req[k], e_mreq[k]);
                chk("busy", k, busy[k], e_busy[k]);
                chk("timeout_err", k, terr[k], e_terr[k]);
                chk("p0_ready", k, rdy[k][0], e_rdy[k][0]);
                chk("p1_ready", k, rdy[k][1], e_rdy[k][1]);
                chk("p0_rdata", k, rdata[k][0], e_rdata[k][0]);
                chk("p1_rdata", k, rdata[k][1], e_rdata[k][1]);
                if (e_mreq[k]) begin
                    chk("m_we", k, m_we[k], e_we[k]);
                    chk("m_addr", k, m_addr[k], e_addr[k]);
                    chk("m_wdata", k, m_wdata[k], e_wdata[k]);
                end
                if (e_busy[k]) chk("owner", k, owner[k], e_owner[k]);
                if (m_req[k] === 1'b1 && !prev_mreq[k]) begin
                    if (k == 0) dgr0.push_back(int'(owner[k]));
                    else        dgr1.push_back(int'(owner[k]));
                end
                prev_mreq[k] = (m_req[k] === 1'b1);
            end
        end
    end

    // Memory responder: answers lat cycles after m_req, or never when lat <= 0.
    int lat [NI];
    int rcnt [NI];
    int stale_req = 0;
    int stale_done = 0;
    logic [15:0] mem [int];
    initial begin
        int key;
        for (int k = 0; k < NI; k++) begin
            m_ready[k] = 1'b0; m_rdata[k] = '0; rcnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                m_ready[k] = 1'b0;
                m_rdata[k] = 16'($urandom);
                if (k == 0 && stale_done != stale_req) begin
                    stale_done = stale_req;
                    m_ready[k] = 1'b1;
                    m_rdata[k] = 16'h7777;
                end else if (m_req[k] === 1'b1) begin
                    rcnt[k]++;
                    if (lat[k] > 0 && rcnt[k] == lat[k]) begin
                        key = k * 65536 + int'(m_addr[k]);
                        if (m_we[k]) mem[key] = m_wdata[k];
                        else m_rdata[k] = mem.exists(key) ? mem[key] : (m_addr[k] ^ 16'h5A5A);
                        m_ready[k] = 1'b1;
                    end
                end else begin
                    rcnt[k] = 0;
                end
            end
        end
    end

    task automatic wait_idle(int k);
        int n = 0;
        while (busy[k] !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", k, busy[k], 1'b0);
    endtask

    // One transaction on an idle instance; returns the number of cycles m_req was high.
    task automatic do_txn(int k, int p, bit w, logic [15:0] a, logic [15:0] d, output int mcyc);
        int n = 0;
        wait_idle(k);
        req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
        @(negedge clk);
        chk("grant_mreq", k, m_req[k], 1'b1);
        chk("grant_addr", k, m_addr[k], a);
        chk("grant_owner", k, owner[k], p[0]);
        mcyc = 0;
        while (rdy[k][p] !== 1'b1 && n < 60) begin
            if (m_req[k] === 1'b1) mcyc++;
            @(negedge clk);
            n++;
        end
        chk("ready_seen", k, rdy[k][p], 1'b1);
        req[k][p] = 1'b0;
    endtask

    initial begin
        int mc, n, cnt, n0, n1;
        int exp_rr [4];
        int exp_fp [4];
        exp_rr = '{0, 1, 0, 1};
        exp_fp = '{0, 0, 0, 1};
        for (int k = 0; k < NI; k++) begin
            lat[k] = 5;
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 0; we[k][p] = 0; addr[k][p] = '0; wdata[k][p] = '0;
            end
        end
        mem[16'h1234] = 16'hBEEF;
        mem[16'h0010] = 16'hA010;
        mem[16'h00AA] = 16'h00AA;

        repeat (2) @(negedge clk);
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_mreq", 0, m_req[0], 1'b0);
        chk("rst_p0_rdata", 0, rdata[0][0], 16'h0000);
        #2 reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: p0 first, then strict alternation.
        dgr0.delete();
        req[0][0] = 1; we[0][0] = 0; addr[0][0] = 16'h0010;
        req[0][1] = 1; we[0][1] = 1; addr[0][1] = 16'h0020; wdata[0][1] = 16'h5555;
        n = 0; cnt = 0;
        while (cnt < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (rdy[0][0] === 1'b1 || rdy[0][1] === 1'b1) cnt++;
        end
        req[0][0] = 0; req[0][1] = 0;
        chk("rr_done_count", 0, cnt, 4);
        wait_idle(0);
        @(negedge clk);
        chk("rr_grant_count", 0, dgr0.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rr_grant_seq", 0, (i < dgr0.size()) ? dgr0[i] : -1, exp_rr[i]);
        chk("rr_p1_write_data", 0, mem.exists(16'h0020) ? mem[16'h0020] : 16'h0, 16'h5555);
        chk("rr_p0_rdata", 0, rdata[0][0], 16'hA010);

        // Single read with a 5-cycle controller.
        do_txn(0, 0, 1'b0, 16'h1234, 16'h0, mc);
        chk("read_mreq_cycles", 0, mc, 5);
        chk("read_rdata", 0, rdata[0][0], 16'hBEEF);
        chk("read_p1_quiet", 0, rdy[0][1], 1'b0);

        // Watchdog abort on port 1.
        lat[0] = 0;
        do_txn(0, 1, 1'b0, 16'h0040, 16'h0, mc);
        chk("to_mreq_cycles", 0, mc, 16);
        chk("to_err_pulse", 0, terr[0], 1'b1);
        chk("to_rdata", 0, rdata[0][1], 16'hFFFF);
        @(negedge clk);
        chk("to_busy_clear", 0, busy[0], 1'b0);
        chk("to_err_single", 0, terr[0], 1'b0);
        lat[0] = 5;

        // A completed write leaves the previous read data in place.
        do_txn(0, 0, 1'b0, 16'h00AA, 16'h0, mc);
        chk("wr_pre_rdata", 0, rdata[0][0], 16'h00AA);
        do_txn(0, 0, 1'b1, 16'h00AB, 16'h1111, mc);
        chk("wr_keep_rdata", 0, rdata[0][0], 16'h00AA);
        chk("wr_mem", 0, mem.exists(16'h00AB) ? mem[16'h00AB] : 16'h0, 16'h1111);

        // Reset in the middle of a port 1 transaction.
        lat[0] = 0;
        wait_idle(0);
        req[0][1] = 1; we[0][1] = 0; addr[0][1] = 16'h0050;
        repeat (3) @(negedge clk);
        chk("mid_busy", 0, busy[0], 1'b1);
        chk("mid_owner", 0, owner[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_mreq", 0, m_req[0], 1'b0);
        chk("async_busy", 0, busy[0], 1'b0);
        chk("async_owner", 0, owner[0], 1'b0);
        req[0][1] = 0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        stale_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_p0_ready", 0, rdy[0][0], 1'b0);
            chk("stale_p1_ready", 0, rdy[0][1], 1'b0);
            chk("stale_p1_rdata", 0, rdata[0][1], 16'h0000);
        end
        lat[0] = 5;
        do_txn(0, 0, 1'b0, 16'h1234, 16'h0, mc);
        chk("post_rst_rdata", 0, rdata[0][0], 16'hBEEF);

        // Fixed priority: port 0 keeps winning until it lets go.
        dgr1.delete();
        req[1][0] = 1; we[1][0] = 0; addr[1][0] = 16'h0100;
        req[1][1] = 1; we[1][1] = 0; addr[1][1] = 16'h0200;
        n = 0; n0 = 0; n1 = 0;
        while (n0 < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (rdy[1][0] === 1'b1) n0++;
            if (rdy[1][1] === 1'b1) n1++;
        end
        req[1][0] = 0;
        chk("fp_p0_served", 1, n0, 3);
        chk("fp_p1_starved", 1, n1, 0);
        n = 0;
        while (rdy[1][1] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("fp_p1_served", 1, rdy[1][1], 1'b1);
        req[1][1] = 0;
        wait_idle(1);
        @(negedge clk);
        chk("fp_grant_count", 1, dgr1.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fp_grant_seq", 1, (i < dgr1.size()) ? dgr1[i] : -1, exp_fp[i]);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at t=%0t, expected to finish", $time);
        $fatal(1);
    end

endmodule
